// File: rtl/ppu_vram_pkg.sv
// Shared types, register selects and address helpers for the PPU VRAM access port.
package ppu_vram_pkg;

    typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;
    typedef enum logic [1:0] {TgtChr, TgtNt, TgtPal} target_e;

    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    localparam logic [13:0] PAL_BASE      = 14'h3F00;
    localparam logic [13:0] NT_BASE       = 14'h2000;
    // Palette reads fill the buffer from the nametable byte hidden underneath ($3Fxx -> $2Fxx).
    localparam logic [13:0] PAL_NT_OFFSET = 14'h1000;

    function automatic logic [10:0] nt_fold(input logic [13:0] v, input logic mirror_v);
        return {(mirror_v ? v[10] : v[11]), v[9:0]};
    endfunction

    function automatic target_e addr_target(input logic [13:0] v);
        if (v < NT_BASE) begin
            return TgtChr;
        end
        if (v >= PAL_BASE) begin
            return TgtPal;
        end
        return TgtNt;
    endfunction

endpackage

// File: rtl/ppu_vram_port_palette_ram.sv
// 32x6 palette RAM: synchronous write, asynchronous read, backdrop mirrors folded internally.
module ppu_palette_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [5:0] wdata,
    output logic [5:0] rdata
);

    logic [5:0] mem [32];
    logic [4:0] idx;

    // $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
    always_comb begin
        idx = addr;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            idx[4] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA protocol engine driving CIRAM, the CHR bus and the palette RAM.
module ppu_vram_port
    import ppu_vram_pkg::*;
#(
    parameter int unsigned AW = 14,
    parameter int unsigned CW = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_cs,
    input  logic          cpu_rw,
    input  logic [2:0]    cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic          busy,
    input  logic          inc32,
    input  logic          mirror_v,
    output logic [CW-1:0] ciram_addr,
    output logic          ciram_we,
    output logic [7:0]    ciram_din,
    input  logic [7:0]    ciram_dout,
    output logic [12:0]   chr_addr,
    output logic          chr_we,
    output logic [7:0]    chr_din,
    input  logic [7:0]    chr_dout
);

    state_e        state_q, state_d;
    logic [AW-1:0] v_q, v_d;
    logic [AW-1:0] t_q, t_d;
    logic          w_toggle_q, w_toggle_d;
    logic [7:0]    rd_buf_q, rd_buf_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          inc32_q, inc32_d;
    logic          fetch_chr_q, fetch_chr_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ciram_we_q, ciram_we_d;
    logic          chr_we_q, chr_we_d;
    logic [CW-1:0] ciram_addr_q, ciram_addr_d;
    logic [12:0]   chr_addr_q, chr_addr_d;

    logic          pal_we;
    logic [5:0]    pal_rdata;
    logic [AW-1:0] inc;
    target_e       tgt;

    assign inc = inc32_q ? AW'(32) : AW'(1);
    assign tgt = addr_target(v_q);

    ppu_palette_ram u_palette (
        .clk   (clk),
        .we    (pal_we),
        .addr  (v_q[4:0]),
        .wdata (wdata_q[5:0]),
        .rdata (pal_rdata)
    );

    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        t_d          = t_q;
        w_toggle_d   = w_toggle_q;
        rd_buf_d     = rd_buf_q;
        wdata_d      = wdata_q;
        inc32_d      = inc32_q;
        fetch_chr_d  = fetch_chr_q;
        cpu_dout_d   = cpu_dout_q;
        ciram_addr_d = ciram_addr_q;
        chr_addr_d   = chr_addr_q;
        cpu_ack_d    = 1'b0;
        ciram_we_d   = 1'b0;
        chr_we_d     = 1'b0;
        pal_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_cs) begin
                    cpu_ack_d = 1'b1;
                    case (cpu_addr)
                        REG_STATUS: begin
                            if (cpu_rw) begin
                                w_toggle_d = 1'b0;
                            end
                        end
                        REG_ADDR: begin
                            if (!cpu_rw) begin
                                if (!w_toggle_q) begin
                                    t_d[13:8]  = cpu_din[5:0];
                                    w_toggle_d = 1'b1;
                                end else begin
                                    t_d[7:0]   = cpu_din;
                                    v_d        = {t_q[13:8], cpu_din};
                                    w_toggle_d = 1'b0;
                                end
                            end
                        end
                        REG_DATA: begin
                            cpu_ack_d = 1'b0;
                            inc32_d   = inc32;
                            wdata_d   = cpu_din;
                            if (!cpu_rw) begin
                                state_d = StWrite;
                                if (tgt == TgtChr) begin
                                    chr_we_d   = 1'b1;
                                    chr_addr_d = v_q[12:0];
                                end else if (tgt == TgtNt) begin
                                    ciram_we_d   = 1'b1;
                                    ciram_addr_d = nt_fold(v_q, mirror_v);
                                end
                            end else begin
                                state_d = StFetch;
                                if (tgt == TgtPal) begin
                                    cpu_dout_d   = {2'b00, pal_rdata};
                                    fetch_chr_d  = 1'b0;
                                    ciram_addr_d = nt_fold(v_q - PAL_NT_OFFSET, mirror_v);
                                end else if (tgt == TgtChr) begin
                                    cpu_dout_d  = rd_buf_q;
                                    fetch_chr_d = 1'b1;
                                    chr_addr_d  = v_q[12:0];
                                end else begin
                                    cpu_dout_d   = rd_buf_q;
                                    fetch_chr_d  = 1'b0;
                                    ciram_addr_d = nt_fold(v_q, mirror_v);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StWrite: begin
                pal_we    = (tgt == TgtPal);
                v_d       = v_q + inc;
                state_d   = StIdle;
                cpu_ack_d = 1'b1;
            end
            StFetch: begin
                rd_buf_d  = fetch_chr_q ? chr_dout : ciram_dout;
                v_d       = v_q + inc;
                state_d   = StIdle;
                cpu_ack_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            v_q          <= '0;
            t_q          <= '0;
            w_toggle_q   <= 1'b0;
            rd_buf_q     <= '0;
            wdata_q      <= '0;
            inc32_q      <= 1'b0;
            fetch_chr_q  <= 1'b0;
            cpu_dout_q   <= '0;
            cpu_ack_q    <= 1'b0;
            ciram_we_q   <= 1'b0;
            chr_we_q     <= 1'b0;
            ciram_addr_q <= '0;
            chr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            t_q          <= t_d;
            w_toggle_q   <= w_toggle_d;
            rd_buf_q     <= rd_buf_d;
            wdata_q      <= wdata_d;
            inc32_q      <= inc32_d;
            fetch_chr_q  <= fetch_chr_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_ack_q    <= cpu_ack_d;
            ciram_we_q   <= ciram_we_d;
            chr_we_q     <= chr_we_d;
            ciram_addr_q <= ciram_addr_d;
            chr_addr_q   <= chr_addr_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign cpu_dout   = cpu_dout_q;
    assign cpu_ack    = cpu_ack_q;
    assign ciram_we   = ciram_we_q;
    assign ciram_addr = ciram_addr_q;
    assign ciram_din  = wdata_q;
    assign chr_we     = chr_we_q;
    assign chr_addr   = chr_addr_q;
    assign chr_din    = wdata_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Randomised bench for ppu_vram_port against a memory-level model of the PPUADDR/PPUDATA protocol.
module tb_ppu_vram_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_cs, cpu_rw, inc32, mirror_v;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_ack, busy;
    logic [10:0] ciram_addr;
    logic        ciram_we;
    logic [7:0]  ciram_din, ciram_dout;
    logic [12:0] chr_addr;
    logic        chr_we;
    logic [7:0]  chr_din, chr_dout;

    ppu_vram_port dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_cs     (cpu_cs),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_ack    (cpu_ack),
        .busy       (busy),
        .inc32      (inc32),
        .mirror_v   (mirror_v),
        .ciram_addr (ciram_addr),
        .ciram_we   (ciram_we),
        .ciram_din  (ciram_din),
        .ciram_dout (ciram_dout),
        .chr_addr   (chr_addr),
        .chr_we     (chr_we),
        .chr_din    (chr_din),
        .chr_dout   (chr_dout)
    );

    always #5 clk = ~clk;

    // Device-side memories, driven only by the DUT's pins (negedge-clocked like CIRAM).
    logic [7:0] dev_ciram [2048];
    logic [7:0] dev_chr [8192];
    bit         dev_init = 1'b0;

    always @(negedge clk) begin
        if (!dev_init) begin
            for (int i = 0; i < 2048; i++) dev_ciram[i] = 8'((i + 1) * 17);
            for (int i = 0; i < 8192; i++) dev_chr[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
            dev_init = 1'b1;
        end
        if (ciram_we) dev_ciram[ciram_addr] = ciram_din;
        if (chr_we) dev_chr[chr_addr] = chr_din;
        ciram_dout <= dev_ciram[ciram_addr];
        chr_dout   <= dev_chr[chr_addr];
    end

    // Reference model state.
    int       m_v, m_t;
    bit       m_w;
    bit [7:0] m_buf, m_dout;
    bit [7:0] m_ciram [2048];
    bit [7:0] m_chr [8192];
    bit [5:0] m_pal [32];

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Physical CIRAM index for a $2000-$3FFF address: four logical 1 KiB tables onto two.
    function automatic int nt_index(input int a, input bit mv);
        int off, tbl, phys;
        off  = (a - 'h2000) % 'h1000;
        tbl  = off / 'h400;
        phys = mv ? (tbl % 2) : (tbl / 2);
        return phys * 'h400 + off % 'h400;
    endfunction

    function automatic int pal_index(input int a);
        int i;
        i = a % 32;
        if (i >= 16 && i % 4 == 0) i -= 16;
        return i;
    endfunction

    task automatic reg_access(input bit rw, input bit [2:0] ra, input bit [7:0] d);
        cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = ra; cpu_din = d;
        @(posedge clk); #1;
        cpu_cs = 1'b0;
        check_eq("reg_ack", cpu_ack, 1);
        check_eq("reg_busy", busy, 0);
        check_eq("reg_dout_kept", cpu_dout, m_dout);
        if (!rw && ra == 3'd6) begin
            if (!m_w) begin
                m_t = (m_t & 'hFF) | ((int'(d) & 'h3F) << 8);
                m_w = 1'b1;
            end else begin
                m_t = (m_t & 'h3F00) | int'(d);
                m_v = m_t;
                m_w = 1'b0;
            end
        end else if (rw && ra == 3'd2) begin
            m_w = 1'b0;
        end
    endtask

    task automatic set_addr(input int a);
        bit [7:0] hi;
        hi = 8'(a >> 8) | (8'($urandom) & 8'hC0);
        reg_access(1'b1, 3'd2, 8'h00);
        reg_access(1'b0, 3'd6, hi);
        reg_access(1'b0, 3'd6, 8'(a));
    endtask

    // One PPUDATA access; poke drives an extra strobe while the port is busy.
    task automatic data_access(input bit rw, input bit [7:0] d, input bit poke);
        int       a;
        bit [7:0] exp;
        a = m_v;
        exp = 8'h00;
        cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = 3'd7; cpu_din = d;
        @(posedge clk); #1;
        cpu_cs = 1'b0;
        check_eq("data_busy", busy, 1);
        check_eq("data_ack_early", cpu_ack, 0);
        if (!rw) begin
            if (a < 'h2000) begin
                check_eq("chr_we", chr_we, 1);
                check_eq("chr_waddr", chr_addr, a);
                check_eq("chr_din", chr_din, d);
                check_eq("ciram_we_idle", ciram_we, 0);
                m_chr[a] = d;
            end else if (a < 'h3F00) begin
                check_eq("ciram_we", ciram_we, 1);
                check_eq("ciram_waddr", ciram_addr, nt_index(a, mirror_v));
                check_eq("ciram_din", ciram_din, d);
                check_eq("chr_we_idle", chr_we, 0);
                m_ciram[nt_index(a, mirror_v)] = d;
            end else begin
                check_eq("pal_no_ciram_we", ciram_we, 0);
                check_eq("pal_no_chr_we", chr_we, 0);
                m_pal[pal_index(a)] = d[5:0];
            end
        end else begin
            if (a < 'h2000) begin
                exp = m_buf;
                m_buf = m_chr[a];
                check_eq("chr_raddr", chr_addr, a);
            end else if (a < 'h3F00) begin
                exp = m_buf;
                m_buf = m_ciram[nt_index(a, mirror_v)];
                check_eq("ciram_raddr", ciram_addr, nt_index(a, mirror_v));
            end else begin
                exp = {2'b00, m_pal[pal_index(a)]};
                m_buf = m_ciram[nt_index(a - 'h1000, mirror_v)];
                check_eq("pal_under_raddr", ciram_addr, nt_index(a - 'h1000, mirror_v));
            end
            m_dout = exp;
        end
        if (poke) begin
            cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd6; cpu_din = 8'h15;
        end
        @(posedge clk); #1;
        cpu_cs = 1'b0;
        check_eq("data_ack", cpu_ack, 1);
        check_eq("data_busy_done", busy, 0);
        check_eq("ciram_we_pulse", ciram_we, 0);
        check_eq("chr_we_pulse", chr_we, 0);
        if (rw) check_eq("data_rdata", cpu_dout, exp);
        m_v = (a + (inc32 ? 32 : 1)) % 'h4000;
        if (poke) begin
            @(posedge clk); #1;
            check_eq("busy_strobe_ack", cpu_ack, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, cpu_ack, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_dout"}, cpu_dout, 0);
        check_eq({tag, "_ciram_we"}, ciram_we, 0);
        check_eq({tag, "_chr_we"}, chr_we, 0);
        check_eq({tag, "_ciram_addr"}, ciram_addr, 0);
        check_eq({tag, "_chr_addr"}, chr_addr, 0);
    endtask

    function automatic int rand_vaddr();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, 'h1FFF);
            1:       return $urandom_range('h2000, 'h2FFF);
            2:       return $urandom_range('h3000, 'h3EFF);
            3:       return $urandom_range('h3F00, 'h3FFF);
            default: return $urandom_range('h3FD0, 'h3FFF);
        endcase
    endfunction

    initial begin
        int rst_a;
        reset_n = 1'b0;
        cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_addr = 3'd0; cpu_din = 8'h00;
        inc32 = 1'b0; mirror_v = 1'b1;
        for (int i = 0; i < 2048; i++) m_ciram[i] = 8'((i + 1) * 17);
        for (int i = 0; i < 8192; i++) m_chr[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
        m_v = 0; m_t = 0; m_w = 1'b0; m_buf = 8'h00; m_dout = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Give every palette entry a known value.
        set_addr('h3F00);
        for (int i = 0; i < 32; i++) data_access(1'b0, 8'($urandom), 1'b0);

        // Address latch, vertical mirroring write, then v = $2109 seen by the next write.
        mirror_v = 1'b1;
        set_addr('h2108);
        data_access(1'b0, 8'h5A, 1'b0);
        data_access(1'b0, 8'h5B, 1'b0);

        // One-behind read buffer over CIRAM $000/$001.
        set_addr('h2000);
        repeat (3) data_access(1'b1, 8'h00, 1'b0);

        // Horizontal mirroring: $2400 lands on the same table as $2000.
        mirror_v = 1'b0;
        set_addr('h2400);
        data_access(1'b0, 8'h77, 1'b0);
        set_addr('h2000);
        repeat (2) data_access(1'b1, 8'h00, 1'b0);

        // Palette mirror and immediate palette read.
        mirror_v = 1'b1;
        set_addr('h3F10);
        data_access(1'b0, 8'h3F, 1'b0);
        set_addr('h3F00);
        data_access(1'b1, 8'h00, 1'b0);

        // +32 wrap at the top of the space, then the toggle reset by PPUSTATUS.
        inc32 = 1'b1;
        set_addr('h3FE0);
        data_access(1'b0, 8'h2A, 1'b0);
        inc32 = 1'b0;
        data_access(1'b0, 8'hC3, 1'b0);
        reg_access(1'b0, 3'd6, 8'h12);
        reg_access(1'b1, 3'd2, 8'h00);
        reg_access(1'b0, 3'd6, 8'h3F);
        reg_access(1'b0, 3'd6, 8'h00);
        data_access(1'b1, 8'h00, 1'b0);

        // Strobe while busy must be ignored; the next latch pair exposes any toggle change.
        set_addr('h2222);
        data_access(1'b0, 8'h99, 1'b1);
        data_access(1'b0, 8'h9A, 1'b0);
        reg_access(1'b0, 3'd6, 8'h23);
        reg_access(1'b0, 3'd6, 8'h45);
        data_access(1'b0, 8'h9B, 1'b0);

        for (int n = 0; n < 400; n++) begin
            mirror_v = 1'($urandom);
            inc32 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1:    set_addr(rand_vaddr());
                2, 3, 4: data_access(1'b1, 8'h00, 1'b0);
                5, 6, 7: data_access(1'b0, 8'($urandom), 1'b0);
                8:       reg_access(1'b1, 3'd2, 8'h00);
                default: reg_access(1'($urandom), 3'($urandom_range(0, 5)) & 3'b101,
                                    8'($urandom));
            endcase
        end

        // Asynchronous reset in the middle of a CIRAM write drops the write.
        mirror_v = 1'b1;
        inc32 = 1'b0;
        set_addr('h2345);
        rst_a = nt_index('h2345, 1'b1);
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd7; cpu_din = 8'hA5;
        @(posedge clk); #1;
        cpu_cs = 1'b0;
        check_eq("rst_we_before", ciram_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_eq("rst_write_dropped", dev_ciram[rst_a], m_ciram[rst_a]);
        m_v = 0; m_t = 0; m_w = 1'b0; m_buf = 8'h00; m_dout = 8'h00;
        @(posedge clk); #1;
        data_access(1'b1, 8'h00, 1'b0);
        data_access(1'b1, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
